// File: rtl/seven_segment_counter_if.sv
// rtl/seven_segment_counter_if.sv - switch, clear and display signals of the seven-segment counter
interface seven_segment_counter_if #(
   parameter int NUM_DIGITS = 2
);
   logic                      i_Switch_Up;
   logic                      i_Switch_Down;
   logic                      i_Clear;
   logic [4*NUM_DIGITS-1:0]   o_Count_BCD;
   logic [7*NUM_DIGITS-1:0]   o_Segments;
   logic                      o_Wrap;

   // board / stimulus side: drives the buttons and clear, observes the display
   modport master (
      output i_Switch_Up,
      output i_Switch_Down,
      output i_Clear,
      input  o_Count_BCD,
      input  o_Segments,
      input  o_Wrap
   );

   // counter side
   modport slave (
      input  i_Switch_Up,
      input  i_Switch_Down,
      input  i_Clear,
      output o_Count_BCD,
      output o_Segments,
      output o_Wrap
   );
endinterface

// File: rtl/seven_segment_counter.sv
// rtl/seven_segment_counter.sv - debounced BCD up/down counter with registered seven-segment decode
module seven_segment_counter #(
   parameter int NUM_DIGITS     = 2,
   parameter int MAX_COUNT      = 99,
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   seven_segment_counter_if.slave bus
);

   localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_LIMIT - 1);
   localparam logic [6:0] POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   // Wrap value converted to BCD once, at elaboration.
   function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int value);
      int v;
      logic [4*NUM_DIGITS-1:0] r;
      v = value;
      r = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Active-high GFEDCBA pattern; non-BCD nibbles blank the digit.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   // Ripple a +1 through the digits; a 9 rolls to 0 and carries on.
   function automatic logic [4*NUM_DIGITS-1:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] c);
      logic [4*NUM_DIGITS-1:0] r;
      logic carry;
      r = c;
      carry = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (carry) begin
            if (c[4*k +: 4] == 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = c[4*k +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple a -1 through the digits; a 0 rolls to 9 and borrows on.
   function automatic logic [4*NUM_DIGITS-1:0] bcd_dec(input logic [4*NUM_DIGITS-1:0] c);
      logic [4*NUM_DIGITS-1:0] r;
      logic borrow;
      r = c;
      borrow = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (borrow) begin
            if (c[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = c[4*k +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);
   localparam logic [7*NUM_DIGITS-1:0] SEG_ZERO = {NUM_DIGITS{decode(4'd0) ^ POL}};

   // Index 0 is the up button, index 1 the down button.
   logic [1:0]    raw;
   logic [1:0]    meta;
   logic [1:0]    sync;
   logic [1:0]    stable;
   logic [1:0]    stable_d;
   logic [CW-1:0] db_cnt [2];
   logic [1:0]    press;

   logic [4*NUM_DIGITS-1:0] count;
   logic [4*NUM_DIGITS-1:0] count_next;
   logic                    wrap;
   logic                    wrap_next;
   logic [7*NUM_DIGITS-1:0] segs;

   assign raw = {bus.i_Switch_Down, bus.i_Switch_Up};

   // Two-stage synchroniser, then a debouncer that only follows the input after DEBOUNCE_LIMIT disagreeing edges.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         meta     <= '0;
         sync     <= '0;
         stable   <= '0;
         stable_d <= '0;
         db_cnt   <= '{default: '0};
      end else begin
         for (int s = 0; s < 2; s++) begin
            meta[s]     <= raw[s];
            sync[s]     <= meta[s];
            stable_d[s] <= stable[s];
            if (sync[s] == stable[s]) begin
               db_cnt[s] <= '0;
            end else if (db_cnt[s] == DB_LAST) begin
               stable[s] <= ~stable[s];
               db_cnt[s] <= '0;
            end else begin
               db_cnt[s] <= db_cnt[s] + CW'(1);
            end
         end
      end
   end

   // A press is the first cycle the debounced level is high; releases are ignored.
   assign press = stable & ~stable_d;

   // Next count: clear wins, simultaneous presses cancel, otherwise step with wrap at the ends.
   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      if (bus.i_Clear) begin
         count_next = '0;
      end else if (press[0] && !press[1]) begin
         if (count == MAX_BCD) begin
            count_next = '0;
            wrap_next  = 1'b1;
         end else begin
            count_next = bcd_inc(count);
         end
      end else if (press[1] && !press[0]) begin
         if (count == '0) begin
            count_next = MAX_BCD;
            wrap_next  = 1'b1;
         end else begin
            count_next = bcd_dec(count);
         end
      end
   end

   // Count and wrap-pulse registers.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

   // Registered decode of the current count, one edge behind it, polarity applied last.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         segs <= SEG_ZERO;
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            segs[7*k +: 7] <= decode(count[4*k +: 4]) ^ POL;
         end
      end
   end

   assign bus.o_Count_BCD = count;
   assign bus.o_Segments  = segs;
   assign bus.o_Wrap      = wrap;

endmodule

// File: tb/tb_seven_segment_counter.sv
// tb/tb_seven_segment_counter.sv - directed vector bench for seven_segment_counter
module tb_seven_segment_counter;

   typedef enum int {OP_UP, OP_DOWN, OP_BOTH, OP_CLEAR, OP_GL3, OP_GL4, OP_CLRP} op_e;

   typedef struct {
      op_e        op;
      logic [7:0] exp_bcd;
      int         exp_wraps;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   wrap_seen = 0;
   vec_t vecs[$];

   logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   seven_segment_counter_if #(.NUM_DIGITS(2)) bus ();

   seven_segment_counter #(
      .NUM_DIGITS(2),
      .MAX_COUNT(12),
      .DEBOUNCE_LIMIT(4),
      .ACTIVE_LOW(1)
   ) dut (
      .i_Clk(clk),
      .i_Rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.o_Wrap === 1'b1) wrap_seen++;
   end

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [13:0] seg_exp(input logic [7:0] b);
      return {~pat[b[7:4]], ~pat[b[3:0]]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic add(input op_e op, input logic [7:0] b, input int w);
      vec_t v;
      v.op = op;
      v.exp_bcd = b;
      v.exp_wraps = w;
      vecs.push_back(v);
   endtask

   task automatic do_op(input op_e op);
      case (op)
         OP_UP:    begin bus.i_Switch_Up = 1; tick(8); bus.i_Switch_Up = 0; tick(8); end
         OP_DOWN:  begin bus.i_Switch_Down = 1; tick(8); bus.i_Switch_Down = 0; tick(8); end
         OP_BOTH:  begin
            bus.i_Switch_Up = 1; bus.i_Switch_Down = 1; tick(8);
            bus.i_Switch_Up = 0; bus.i_Switch_Down = 0; tick(8);
         end
         OP_CLEAR: begin bus.i_Clear = 1; tick(1); bus.i_Clear = 0; tick(2); end
         OP_GL3:   begin bus.i_Switch_Up = 1; tick(3); bus.i_Switch_Up = 0; tick(8); end
         OP_GL4:   begin bus.i_Switch_Up = 1; tick(4); bus.i_Switch_Up = 0; tick(10); end
         OP_CLRP:  begin
            bus.i_Switch_Up = 1; tick(6);
            bus.i_Clear = 1; tick(1);
            bus.i_Clear = 0; tick(1);
            bus.i_Switch_Up = 0; tick(8);
         end
         default:  tick(1);
      endcase
   endtask

   initial begin
      int w0;
      bus.i_Switch_Up = 0;
      bus.i_Switch_Down = 0;
      bus.i_Clear = 0;

      // reset state
      #1 rst = 1;
      #1;
      chk("reset_count", 32'(bus.o_Count_BCD), 32'h00);
      chk("reset_segs", 32'(bus.o_Segments), 32'(14'b1000000_1000000));
      chk("reset_wrap", 32'(bus.o_Wrap), 32'd0);
      tick(2);
      rst = 0;
      tick(2);

      // first press latency and single step over a long hold
      bus.i_Switch_Up = 1;
      tick(6);
      chk("lat_before", 32'(bus.o_Count_BCD), 32'h00);
      tick(1);
      chk("lat_count", 32'(bus.o_Count_BCD), 32'h01);
      chk("lat_segs_old", 32'(bus.o_Segments), 32'(14'b1000000_1000000));
      tick(1);
      chk("lat_segs_new", 32'(bus.o_Segments), 32'(14'b1000000_1111001));
      tick(20);
      chk("hold_one_step", 32'(bus.o_Count_BCD), 32'h01);
      bus.i_Switch_Up = 0;
      tick(10);
      chk("hold_no_wrap", 32'(wrap_seen), 32'd0);

      // vector table
      add(OP_CLEAR, 8'h00, 0);
      for (int i = 1; i <= 12; i++) add(OP_UP, bcd(i), 0);
      add(OP_UP, 8'h00, 1);
      add(OP_DOWN, 8'h12, 1);
      add(OP_DOWN, 8'h11, 0);
      add(OP_DOWN, 8'h10, 0);
      add(OP_DOWN, 8'h09, 0);
      add(OP_GL3, 8'h09, 0);
      add(OP_GL4, 8'h10, 0);
      add(OP_BOTH, 8'h10, 0);
      add(OP_CLEAR, 8'h00, 0);
      for (int i = 1; i <= 7; i++) add(OP_UP, bcd(i), 0);
      add(OP_CLRP, 8'h00, 0);
      for (int i = 1; i <= 11; i++) add(OP_UP, bcd(i), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         w0 = wrap_seen;
         do_op(vecs[i].op);
         chk($sformatf("vec%0d_count", i), 32'(bus.o_Count_BCD), 32'(vecs[i].exp_bcd));
         chk($sformatf("vec%0d_segs", i), 32'(bus.o_Segments), 32'(seg_exp(vecs[i].exp_bcd)));
         chk($sformatf("vec%0d_wraps", i), 32'(wrap_seen - w0), 32'(vecs[i].exp_wraps));
      end

      // asynchronous reset mid-clock at count 11
      chk("pre_rst_count", 32'(bus.o_Count_BCD), 32'h11);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("async_rst_count", 32'(bus.o_Count_BCD), 32'h00);
      chk("async_rst_segs", 32'(bus.o_Segments), 32'(14'b1000000_1000000));

      // switch held across reset release yields exactly one press
      bus.i_Switch_Up = 1;
      tick(3);
      rst = 0;
      w0 = wrap_seen;
      tick(20);
      chk("held_rst_count", 32'(bus.o_Count_BCD), 32'h01);
      bus.i_Switch_Up = 0;
      tick(10);
      chk("held_rst_final", 32'(bus.o_Count_BCD), 32'h01);
      chk("held_rst_wrap", 32'(wrap_seen - w0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_segment_counter.md
# seven_segment_counter

Parametrised N-digit BCD up/down counter driving N seven-segment digits, for the board's switch-driven display designs. Two push-buttons are synchronised and debounced in-block; each clean press steps the count up or down with BCD carry/borrow. The count wraps at a configurable maximum, and each digit is decoded to registered segment outputs with selectable polarity. It sits between raw board switches and the segment pins.

## Interface
- NUM_DIGITS, 2, number of BCD digits (1..4)
- MAX_COUNT, 99, wrap value (0 < MAX_COUNT ≤ 10^NUM_DIGITS − 1)
- DEBOUNCE_LIMIT, 250000, consecutive cycles of input disagreement before accepting a switch change (≥1; 10 ms at 25 MHz)
- ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)

- i_Clk  in  1  main 25 MHz clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Switch_Up  in  1  raw, asynchronous up button
- i_Switch_Down  in  1  raw, asynchronous down button
- i_Clear  in  1  synchronous clear, sampled on i_Clk
- o_Count_BCD  out  4*NUM_DIGITS  current count; digit k at bits [4k+3:4k], k=0 least significant
- o_Segments  out  7*NUM_DIGITS  digit k segment A..G at bits 7k+0..7k+6
- o_Wrap  out  1  one-cycle pulse when count wraps in either direction

## Operation
- Per switch: 2-FF synchroniser (reset 0), then debouncer holding a stable state (reset 0) and a counter (reset 0).
  - Synchroniser output equals stable: counter ← 0.
  - Otherwise counter increments. On the DEBOUNCE_LIMIT-th consecutive disagreeing edge, stable flips and counter ← 0.
- Press pulse: stable rising edge (stable = 1, previous stable = 0), one cycle wide. Releases generate nothing.
- Count update priority, evaluated on each edge:
  - i_Clear = 1: count ← 0, o_Wrap = 0, any same-cycle press is discarded.
  - Up and down presses in the same cycle: no change, o_Wrap = 0.
  - Up only: count = MAX_COUNT → count ← 0, o_Wrap = 1. Otherwise +1, with a digit at 9 → 0 carrying into the next digit.
  - Down only: count = 0 → count ← MAX_COUNT, o_Wrap = 1. Otherwise −1, with a digit at 0 → 9 borrowing from the next digit.
- Count is always valid BCD in the range 0..MAX_COUNT. No binary intermediate is exposed.
- Segment decode per digit, as GFEDCBA, active-high:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any other nibble = 0000000.
- ACTIVE_LOW = 1 inverts every segment bit after decode.

## Timing
- Reset (asynchronous, takes effect immediately):
  - o_Count_BCD = 0 and o_Wrap = 0.
  - o_Segments = digit-0 pattern on every digit, i.e. 7'b1000000 per digit when ACTIVE_LOW = 1.
  - All synchroniser, debounce and edge registers are cleared.
- Reset mid-debounce or mid-press: the press is lost. A switch held across reset release re-debounces from 0 and produces one press.
- Latency, with edge 0 the first edge sampling a raw input change held steady:
  - Synchroniser output changes at edge 1.
  - Stable flips at edge 1 + DEBOUNCE_LIMIT.
  - o_Count_BCD updates at edge 2 + DEBOUNCE_LIMIT; o_Wrap is high for exactly that cycle.
  - o_Segments update one edge later (registered decode).
- A glitch shorter than DEBOUNCE_LIMIT synchronised cycles clears the counter and causes no press.
- i_Clear takes effect at the next edge. o_Count_BCD changes at that edge and o_Segments one edge later.

## Test plan
- Config used: NUM_DIGITS=2, MAX_COUNT=12, DEBOUNCE_LIMIT=4, ACTIVE_LOW=1.
- Reset, then hold i_Switch_Up high → count goes 00→01 exactly 6 edges after the first sampled high edge. o_Segments digit 0 = 7'b1111001 one edge later. Only one step for the whole hold.
- 12 clean up presses from 00 → count 12, no o_Wrap. 13th press → count 00 with a single-cycle o_Wrap. Press at 09 → 10, exercising the carry.
- Down press at 00 → count 12 with o_Wrap pulse. Down press at 10 → 09, exercising the borrow.
- Up glitch high for 3 synchronised cycles, then low → count unchanged, no o_Wrap. Glitch of 4+ cycles → one step.
- Up and down presses timed to pulse on the same edge → count unchanged. i_Clear asserted in the cycle of an up press at count 07 → count 00, o_Wrap 0.
- Assert i_Rst asynchronously mid-clock at count 11 → o_Count_BCD = 00 and segments = 7'b1000000 per digit immediately, before the next edge.
